// File: rtl/conv_pkg.sv
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared types and constants for the 3x3 convolution datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int DATA_W = 16;
    localparam int KSIZE  = 3;

    // index = row*KSIZE + col, row 0 = oldest (top), col 0 = leftmost
    typedef logic [KSIZE*KSIZE-1:0][DATA_W-1:0] win3x3_t;

endpackage

`default_nettype wire

// File: rtl/conv_line_buffer.sv
// ============================================================================
// Module   : conv_line_buffer
// Brief    : One-row pixel delay; read-before-write at the same address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_line_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 28,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    // Contents are never reset: every location is rewritten before it is read
    // back within a frame.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[addr];

endmodule

`default_nettype wire

// File: rtl/conv_window_gen.sv
// ============================================================================
// Module   : conv_window_gen
// Brief    : Raster FP16 stream to valid 3x3 windows; two line buffers.
//            Optional stride-2 output selection via CONV_WIN_STRIDE2_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_gen
    import conv_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_W-1:0]                      in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [KSIZE*KSIZE-1:0][DATA_W-1:0]     out_win,
    output logic                                   out_last
);

    localparam int c_col_w = $clog2(IMG_W);
    localparam int c_row_w = $clog2(IMG_H);
`ifdef CONV_WIN_STRIDE2_EN
    localparam int c_last_r = ((IMG_H - 1) % 2 == 0) ? IMG_H - 1 : IMG_H - 2;
    localparam int c_last_c = ((IMG_W - 1) % 2 == 0) ? IMG_W - 1 : IMG_W - 2;
`else
    localparam int c_last_r = IMG_H - 1;
    localparam int c_last_c = IMG_W - 1;
`endif

    if (IMG_W < KSIZE) begin : g_img_w_check
        $error("conv_window_gen: IMG_W must be >= 3");
    end
    if (IMG_H < KSIZE) begin : g_img_h_check
        $error("conv_window_gen: IMG_H must be >= 3");
    end

    logic [c_col_w-1:0]                    r_col_cnt;
    logic [c_row_w-1:0]                    r_row_cnt;
    logic                                  r_out_valid;
    logic                                  r_out_last;
    logic [KSIZE*KSIZE-1:0][DATA_W-1:0]    r_win;
    logic [DATA_W-1:0]                     w_lb0_rd;
    logic [DATA_W-1:0]                     w_lb1_rd;
    logic                                  w_accept;
    logic                                  w_col_wrap;
    logic                                  w_row_wrap;
    logic                                  w_in_range;
    logic                                  w_win_hit;
    logic                                  w_last_hit;

    assign in_ready   = ~r_out_valid | out_ready;
    assign w_accept   = in_valid & in_ready;
    assign w_col_wrap = (r_col_cnt == c_col_w'(IMG_W - 1));
    assign w_row_wrap = (r_row_cnt == c_row_w'(IMG_H - 1));
    assign w_in_range = (r_row_cnt >= c_row_w'(KSIZE - 1)) &&
                        (r_col_cnt >= c_col_w'(KSIZE - 1));
    assign w_last_hit = (r_row_cnt == c_row_w'(c_last_r)) &&
                        (r_col_cnt == c_col_w'(c_last_c));

`ifdef CONV_WIN_STRIDE2_EN
    // (r-2) even is the same as r even
    assign w_win_hit = w_in_range & ~r_row_cnt[0] & ~r_col_cnt[0];
`else
    assign w_win_hit = w_in_range;
`endif

    conv_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (c_col_w)
    ) u_lb0 (
        .clk     (clk),
        .wr_en   (w_accept),
        .addr    (r_col_cnt),
        .wr_data (in_data),
        .rd_data (w_lb0_rd)
    );

    conv_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .ADDR_W (c_col_w)
    ) u_lb1 (
        .clk     (clk),
        .wr_en   (w_accept),
        .addr    (r_col_cnt),
        .wr_data (w_lb0_rd),
        .rd_data (w_lb1_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_cnt   <= '0;
            r_row_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_win       <= '0;
        end else if (w_accept) begin
            r_col_cnt <= w_col_wrap ? '0 : r_col_cnt + 1'b1;
            if (w_col_wrap) begin
                r_row_cnt <= w_row_wrap ? '0 : r_row_cnt + 1'b1;
            end
            for (int row = 0; row < KSIZE; row++) begin
                for (int col = 0; col < KSIZE - 1; col++) begin
                    r_win[row*KSIZE + col] <= r_win[row*KSIZE + col + 1];
                end
            end
            r_win[KSIZE-1]         <= w_lb1_rd;
            r_win[2*KSIZE-1]       <= w_lb0_rd;
            r_win[KSIZE*KSIZE-1]   <= in_data;
            r_out_valid <= w_win_hit;
            r_out_last  <= w_win_hit & w_last_hit;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_win   = r_win;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_gen.sv
// ============================================================================
// Module   : tb_conv_window_gen
// Brief    : Self-checking bench for conv_window_gen (4x4 and 5xN instances).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_conv_window_gen;
    import conv_pkg::*;

    localparam int AW = 4;
    localparam int AH = 4;
    localparam int BW = 5;
`ifdef CONV_WIN_STRIDE2_EN
    localparam int STRIDE = 2;
    localparam int BH = 5;
`else
    localparam int STRIDE = 1;
    localparam int BH = 7;
`endif
    localparam int CW = $bits(win3x3_t);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              sel = 1'b0;
    logic [DATA_W-1:0] in_data = '0;

    logic    a_in_ready, a_out_valid, a_out_last;
    logic    b_in_ready, b_out_valid, b_out_last;
    win3x3_t a_out_win, b_out_win;
    logic    in_ready, out_valid, out_last;
    win3x3_t out_win;

    conv_window_gen #(.DATA_W(DATA_W), .IMG_W(AW), .IMG_H(AH)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & ~sel),
        .in_ready  (a_in_ready),
        .in_data   (in_data),
        .out_valid (a_out_valid),
        .out_ready (out_ready & ~sel),
        .out_win   (a_out_win),
        .out_last  (a_out_last)
    );

    conv_window_gen #(.DATA_W(DATA_W), .IMG_W(BW), .IMG_H(BH)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & sel),
        .in_ready  (b_in_ready),
        .in_data   (in_data),
        .out_valid (b_out_valid),
        .out_ready (out_ready & sel),
        .out_win   (b_out_win),
        .out_last  (b_out_last)
    );

    assign in_ready  = sel ? b_in_ready  : a_in_ready;
    assign out_valid = sel ? b_out_valid : a_out_valid;
    assign out_last  = sel ? b_out_last  : a_out_last;
    assign out_win   = sel ? b_out_win   : a_out_win;

    int checks = 0;
    int failures = 0;

    // reference model state: frame image, raster position, pending windows
    logic [DATA_W-1:0] pix [0:15][0:15];
    int                mr = 0;
    int                mc = 0;
    win3x3_t           exp_q[$];
    bit                last_q[$];
    bit                exp_ov = 1'b0;
    int                n_win = 0;
    bit                want_first = 1'b0;
    win3x3_t           first_ref;
    int                first_vals [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};

    task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_win(input int r, input int c);
        return r >= 2 && c >= 2 && ((r - 2) % STRIDE == 0) && ((c - 2) % STRIDE == 0);
    endfunction

    function automatic bit is_last(input int r, input int c, input int w, input int h);
        int lr = -1;
        int lc = -1;
        for (int i = 0; i < h; i++)
            for (int j = 0; j < w; j++)
                if (is_win(i, j)) begin lr = i; lc = j; end
        return r == lr && c == lc;
    endfunction

    function automatic int count_win(input int w, input int h);
        int n = 0;
        for (int i = 0; i < h; i++)
            for (int j = 0; j < w; j++)
                if (is_win(i, j)) n++;
        return n;
    endfunction

    task automatic model_accept(input logic [DATA_W-1:0] d, input int w, input int h, output bit pushed);
        win3x3_t wv;
        pix[mr][mc] = d;
        pushed = is_win(mr, mc);
        if (pushed) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    wv[i*3 + j] = pix[mr-2+i][mc-2+j];
            exp_q.push_back(wv);
            last_q.push_back(is_last(mr, mc, w, h));
        end
        mc++;
        if (mc == w) begin
            mc = 0;
            mr++;
            if (mr == h) mr = 0;
        end
    endtask

    task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit rdy,
                         input int w, input int h, output bit acc);
        bit ov_next;
        bit pushed;
        win3x3_t wv;
        bit lst;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        #1;
        check_eq("out_valid", CW'(out_valid), CW'(exp_ov));
        check_eq("in_ready", CW'(in_ready), CW'(!exp_ov || rdy));
        acc = in_valid && in_ready;
        if (out_valid && rdy) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_win", CW'(1), CW'(0));
            end else begin
                wv  = exp_q.pop_front();
                lst = last_q.pop_front();
                check_eq("win", out_win, wv);
                check_eq("last", CW'(out_last), CW'(lst));
                if (want_first) begin
                    check_eq("first_win", out_win, first_ref);
                    want_first = 1'b0;
                end
                n_win++;
            end
        end
        ov_next = exp_ov && !rdy;
        if (acc) begin
            model_accept(d, w, h, pushed);
            if (pushed) ov_next = 1'b1;
        end
        exp_ov = ov_next;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (n) begin
            @(negedge clk);
            #1;
            check_eq("rst_valid", CW'(out_valid), CW'(0));
        end
        check_eq("rst_last", CW'(out_last), CW'(0));
        check_eq("rst_win", out_win, '0);
        rst = 1'b0;
        mr = 0;
        mc = 0;
        exp_q.delete();
        last_q.delete();
        exp_ov = 1'b0;
    endtask

    task automatic run_frame(input int w, input int h, input int base, input int pv,
                             input int pr, input int stall_n, input int npix_lim);
        int k = 0;
        int guard = 0;
        int npix;
        bit acc;
        bit v;
        bit rdy;
        bit stall_done = 1'b0;
        win3x3_t held;
        logic [DATA_W-1:0] d;
        npix = (npix_lim > 0) ? npix_lim : w * h;
        while (k < npix) begin
            if (guard > 20 * w * h + 100) begin
                check_eq("frame_timeout", CW'(0), CW'(1));
                break;
            end
            guard++;
            d = DATA_W'(base + (k / w) * w + (k % w) + 1);
            if (stall_n > 0 && !stall_done && exp_ov) begin
                stall_done = 1'b1;
                @(posedge clk);
                #1;
                held = out_win;
                for (int s = 0; s < stall_n; s++) begin
                    cycle(1'b1, d, 1'b0, w, h, acc);
                    if (acc) k++;
                    @(posedge clk);
                    #1;
                    check_eq("stall_win", out_win, held);
                    check_eq("stall_in_ready", CW'(in_ready), CW'(0));
                end
                continue;
            end
            v   = ($urandom_range(99) < pv);
            rdy = ($urandom_range(99) < pr);
            cycle(v, d, rdy, w, h, acc);
            if (acc) k++;
        end
    endtask

    task automatic drain(input int w, input int h);
        bit acc;
        int n = 0;
        while ((exp_q.size() > 0 || exp_ov) && n < 50) begin
            cycle(1'b0, '0, 1'b1, w, h, acc);
            n++;
        end
        check_eq("drain_empty", CW'(exp_q.size()), CW'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 9; k++) first_ref[k] = DATA_W'(first_vals[k]);

        sel = 1'b0;
        do_reset(2);

        // clean 4x4 frame, continuous flow
        n_win = 0;
        want_first = 1'b1;
        run_frame(AW, AH, 0, 100, 100, 0, 0);
        drain(AW, AH);
        check_eq("nwin_clean", CW'(n_win), CW'(count_win(AW, AH)));

        // backpressure on the first window
        n_win = 0;
        want_first = 1'b1;
        run_frame(AW, AH, 0, 100, 100, 5, 0);
        drain(AW, AH);
        check_eq("nwin_stall", CW'(n_win), CW'(count_win(AW, AH)));

        // two frames back to back, second offset by 100
        n_win = 0;
        run_frame(AW, AH, 0, 100, 100, 0, 0);
        run_frame(AW, AH, 100, 100, 100, 0, 0);
        drain(AW, AH);
        check_eq("nwin_b2b", CW'(n_win), CW'(2 * count_win(AW, AH)));

        // reset after 6 pixels, then a fresh frame
        run_frame(AW, AH, 0, 100, 100, 0, 6);
        do_reset(2);
        n_win = 0;
        want_first = 1'b1;
        run_frame(AW, AH, 0, 100, 100, 0, 0);
        drain(AW, AH);
        check_eq("nwin_after_rst", CW'(n_win), CW'(count_win(AW, AH)));
        check_eq("first_seen", CW'(want_first), CW'(0));

        // random gaps on the larger instance, two frames
        sel = 1'b1;
        do_reset(2);
        n_win = 0;
        run_frame(BW, BH, 0, 70, 60, 0, 0);
        run_frame(BW, BH, 200, 60, 70, 0, 0);
        drain(BW, BH);
        check_eq("nwin_random", CW'(n_win), CW'(2 * count_win(BW, BH)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Producer side of the 3x3 convolution kernel datapath. Consumes a raster-order FP16 feature-map stream, one pixel per accepted beat.
- Buffers two previous rows and emits valid (unpadded) 3x3 windows in exactly the packed layout the kernel's ifmap_3x3 input takes.
- Sits between the ifmap fetch/DMA stream and the conv kernel array.

Parameters:
- DATA_W, 16, pixel width (FP16 bit pattern, passed through untouched)
- IMG_W, 28, pixels per row; must be >= 3 (elaboration assertion)
- IMG_H, 28, rows per frame; must be >= 3 (elaboration assertion)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  pixel present
- in_ready  out  1  pixel accepted when in_valid & in_ready
- in_data  in  DATA_W  pixel, raster order (row-major, left to right)
- out_valid  out  1  window present
- out_ready  in  1  window consumed when out_valid & out_ready
- out_win  out  [8:0][DATA_W-1:0]  window; index = row*3+col, row 0 = oldest (top), col 0 = leftmost
- out_last  out  1  qualifies last window of the frame

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, out_last=0, out_win=0, col_cnt=0, row_cnt=0. Line-buffer contents are not reset; they are never exposed before being rewritten in the current frame. Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).
- in_ready = ~out_valid | out_ready (combinational; single output stage, no bubble under continuous flow).
- On accept of pixel p at (r,c):
  - new column = {lb1[c], lb0[c], p} as top/mid/bottom.
  - Then lb1[c] <= lb0[c], lb0[c] <= p.
  - Window shifts left: col0 <= col1, col1 <= col2, col2 <= new column.
- out_win is the window register itself; it shifts only on accept.
- out_valid next cycle = (accept & r>=2 & c>=2) | (out_valid & ~out_ready).
- Latency: window whose bottom-right pixel is (r,c) appears 1 cycle after that pixel is accepted.
- Counters:
  - col_cnt increments on accept; wraps IMG_W-1 -> 0 and increments row_cnt.
  - At (IMG_H-1, IMG_W-1), both wrap to 0.
  - Back-to-back frames need no gap.
- out_last=1 with the window from pixel (IMG_H-1, IMG_W-1); held alongside out_valid while stalled.
- Stalls:
  - out_valid & ~out_ready: out_win, out_last, counters and line buffers hold; in_ready=0.
  - Accept and consume in the same cycle is legal: the new window replaces the consumed one.
- Windows per frame: (IMG_W-2)*(IMG_H-2). Rows 0-1 and columns 0-1 of each row produce no output but still update buffers.

Optional Feature:
- Macro: CONV_WIN_STRIDE2_EN.
- Defined: the valid condition additionally requires (r-2) even and (c-2) even (stride-2). out_last is asserted on the last emitted window, i.e. the one with the largest r and c satisfying the stride condition.
- Undefined: stride 1 as above. Counters and line buffers are identical in both modes.

Decomposition:
- Shared package conv_pkg:
  - localparam DATA_W=16.
  - typedef logic [8:0][DATA_W-1:0] win3x3_t, reused by the kernel.
  - localparam KSIZE=3.
- One natural sub-module: conv_line_buffer, an IMG_W-deep, DATA_W-wide row delay with an address/write-enable port, instantiated twice (lb0, lb1).

Test Plan:
- IMG_W=IMG_H=4, pixel = r*4+c+1, continuous valid, out_ready=1:
  - first out_valid 1 cycle after pixel 11 is accepted, out_win = {1,2,3,5,6,7,9,10,11};
  - exactly 4 windows;
  - last window {6,7,8,10,11,12,14,15,16} with out_last=1.
- Backpressure: same stream, out_ready=0 for 5 cycles while the first window is valid -> out_win stable, in_ready=0, no pixel lost; all 4 windows correct afterwards.
- Two 4x4 frames back-to-back, second frame offset +100 -> second frame's first window {101,102,103,105,106,107,109,110,111}; no stale data from frame 1.
- rst asserted after 6 pixels, then a fresh frame -> out_valid=0 during reset; first window matches the clean-frame case.
- Random in_valid/out_ready gaps on a 5x7 frame vs scoreboard model -> 15 windows, order and values exact.
- CONV_WIN_STRIDE2_EN, 5x5 frame, pixel = r*5+c+1 -> 4 windows with bottom-right values 13, 15, 23, 25; out_last only on 25.
